jt12_rst_clr: RTL and testbench
===============================

Name: jt12_rst_clr

Overview:
- Post-reset register-clear sequencer placed directly downstream of the reset synchroniser, between the CPU write bus and the jt12 register interface.
- After reset releases, it owns the chip write port and silences the FM section: all channels keyed off, every operator register in both banks cleared, TL forced to maximum attenuation.
- While the sequence runs, CPU writes are blocked. When it finishes, CPU writes pass through with one clk of latency.

Parameters:
- WAIT, 2: number of idle cen ticks inserted after every chip transaction.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cen  in  1  clock enable; paces sequencer transactions only.
- cpu_addr  in  2  CPU address: bit1 = bank, bit0 = 0 for address write, 1 for data write.
- cpu_din  in  8  CPU write data.
- cpu_wr  in  1  CPU write strobe, one clk wide.
- busy  out  1  high while the clear sequence owns the chip port.
- cpu_lost  out  1  sticky flag: a CPU write arrived while busy.
- chip_addr  out  2  to the jt12 addr input.
- chip_din  out  8  to the jt12 din input.
- chip_wr  out  1  one-clk write strobe to jt12.

Behaviour:
- Reset (async assert): busy=1, cpu_lost=0, chip_wr=0, chip_addr=0, chip_din=0. State=KOFF, counters cleared.
- Sequence starts on the first cen after rst deasserts.
- Transaction rule: chip_wr=1 for exactly one clk, on a cen=1 cycle. It is followed by WAIT cen ticks with chip_wr=0. Each transaction therefore spans 1+WAIT cen ticks.
- Register write = address transaction (chip_addr={bank,0}, chip_din=reg), then data transaction (chip_addr={bank,1}, chip_din=value).
- State KOFF:
  - Six writes in bank 0 to reg 0x28, values in order 0x00, 0x01, 0x02, 0x04, 0x05, 0x06.
  - Then go to CLR with bank=0, reg=0x30.
- State CLR:
  - Write reg in current bank. Value is 0x7F if 0x40 <= reg <= 0x4F, else 0x00.
  - reg increments through 0xB6 inclusive (135 regs).
  - At 0xB6: if bank=0, set bank=1 and reg=0x30; if bank=1, go to PASS.
- Sequence totals:
  - 276 register writes = 552 transactions.
  - Busy phase = 552*(1+WAIT) cen ticks. At WAIT=2 this is 1656 ticks: first chip_wr at tick 0, last at tick 1653.
  - busy goes low on the clk edge of tick 1656.
- State PASS:
  - Each clk (not cen-gated): chip_wr<=cpu_wr, chip_addr<=cpu_addr, chip_din<=cpu_din.
  - Latency 1 clk. busy stays 0 until the next rst.
- CPU arbitration:
  - cpu_wr is honoured only when registered busy=0 at that edge.
  - cpu_wr with busy=1 is dropped and sets cpu_lost. This includes the edge on which busy falls.
- cen=0 cycles: the sequencer holds all state; chip_wr=0.
- Reset mid-sequence or in PASS: immediate return to reset values. The full sequence restarts from KOFF after release.
- Counter widths:
  - reg counter 8 bits.
  - Wait counter sized for WAIT up to 255.
  - WAIT=0 is legal: back-to-back cen ticks each carry a transaction.

Test Plan:
- Release rst with cen=1 every clk, WAIT=2 -> first chip_wr has addr=0, din=0x28; next chip_wr at +3 clk has addr=1, din=0x00; busy falls after 1656 clk.
- Capture all chip writes during busy -> exactly 552 strobes. Bank 0 and bank 1 regs 0x40-0x4F get 0x7F; every other reg in 0x30-0xB6 gets 0x00; the 0x28 values are 0,1,2,4,5,6.
- cen every 4th clk -> same write sequence; strobes only on cen cycles; busy phase = 6624 clk.
- cpu_wr during busy (addr=1, din=0xAA) -> no chip_wr from the CPU; cpu_lost=1 and remains set. After busy=0, cpu_wr addr=2, din=0x55 -> chip_wr, addr=2, din=0x55 one clk later.
- Assert rst at transaction 300 -> outputs reset asynchronously. After release, the sequence restarts at 0x28/0x00 and runs the full 552 transactions.
- WAIT=0, cen=1 -> 552 consecutive clk strobes; busy falls at clk 552.

Source files
------------

// File: rtl/jt12_rst_clr.sv
// rtl/jt12_rst_clr.sv - post-reset FM register clear sequencer with CPU write pass-through
module jt12_rst_clr #(
   parameter int WAIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic [1:0] cpu_addr,
   input  logic [7:0] cpu_din,
   input  logic       cpu_wr,
   output logic       busy,
   output logic       cpu_lost,
   output logic [1:0] chip_addr,
   output logic [7:0] chip_din,
   output logic       chip_wr
);

   localparam logic [7:0] WAIT_CNT = 8'(WAIT);

   // FIN drains the idle ticks after the last transaction before handing over
   typedef enum logic [1:0] {KOFF, CLR, FIN, PASS} state_t;

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [2:0] koff_q, koff_d;
   logic [7:0] reg_q, reg_d;
   logic       bank_q, bank_d;
   logic       data_q, data_d;      // 0: address transaction is next, 1: data transaction
   logic       busy_q, busy_d;
   logic       cpu_lost_q, cpu_lost_d;
   logic [1:0] chip_addr_q, chip_addr_d;
   logic [7:0] chip_din_q, chip_din_d;
   logic       chip_wr_q, chip_wr_d;

   logic       issue;               // sequencer drives a transaction on this clk
   logic [2:0] koff_val;
   logic       txn_bank;
   logic [7:0] txn_reg;
   logic [7:0] txn_val;

   // State register: everything returns to the start of the clear sequence on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= KOFF;
         wait_q      <= 8'd0;
         koff_q      <= 3'd0;
         reg_q       <= 8'd0;
         bank_q      <= 1'b0;
         data_q      <= 1'b0;
         busy_q      <= 1'b1;
         cpu_lost_q  <= 1'b0;
         chip_addr_q <= 2'd0;
         chip_din_q  <= 8'd0;
         chip_wr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         koff_q      <= koff_d;
         reg_q       <= reg_d;
         bank_q      <= bank_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         cpu_lost_q  <= cpu_lost_d;
         chip_addr_q <= chip_addr_d;
         chip_din_q  <= chip_din_d;
         chip_wr_q   <= chip_wr_d;
      end
   end

   // Next state: one sequencer step per cen tick, either an idle tick or a transaction
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      koff_d  = koff_q;
      reg_d   = reg_q;
      bank_d  = bank_q;
      data_d  = data_q;
      busy_d  = busy_q;
      issue   = 1'b0;
      if (cen && state_q != PASS) begin
         if (wait_q != 8'd0) begin
            wait_d = wait_q - 8'd1;
         end else if (state_q == FIN) begin
            state_d = PASS;
            busy_d  = 1'b0;
         end else begin
            issue  = 1'b1;
            wait_d = WAIT_CNT;
            data_d = ~data_q;
            // register pointers advance only once the data half of a write is out
            if (data_q) begin
               if (state_q == KOFF) begin
                  koff_d = koff_q + 3'd1;
                  if (koff_q == 3'd5) begin
                     state_d = CLR;
                     bank_d  = 1'b0;
                     reg_d   = 8'h30;
                  end
               end else begin
                  reg_d = reg_q + 8'd1;
                  if (reg_q == 8'hB6) begin
                     reg_d = 8'h30;
                     if (bank_q) begin
                        state_d = FIN;
                     end else begin
                        bank_d = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   // Outputs: transaction payload while busy, registered CPU pass-through afterwards
   always_comb begin
      // key-off values 0,1,2 then 4,5,6 (channel 3 slot does not exist)
      koff_val = (koff_q < 3'd3) ? koff_q : koff_q + 3'd1;
      if (state_q == KOFF) begin
         txn_bank = 1'b0;
         txn_reg  = 8'h28;
         txn_val  = {5'd0, koff_val};
      end else begin
         txn_bank = bank_q;
         txn_reg  = reg_q;
         txn_val  = (reg_q[7:4] == 4'h4) ? 8'h7F : 8'h00;   // TL regs to max attenuation
      end
      chip_wr_d   = 1'b0;
      chip_addr_d = chip_addr_q;
      chip_din_d  = chip_din_q;
      if (state_q == PASS) begin
         chip_wr_d   = cpu_wr;
         chip_addr_d = cpu_addr;
         chip_din_d  = cpu_din;
      end else if (issue) begin
         chip_wr_d   = 1'b1;
         chip_addr_d = {txn_bank, data_q};
         chip_din_d  = data_q ? txn_val : txn_reg;
      end
      cpu_lost_d = cpu_lost_q | (cpu_wr & busy_q);
   end

   assign busy      = busy_q;
   assign cpu_lost  = cpu_lost_q;
   assign chip_addr = chip_addr_q;
   assign chip_din  = chip_din_q;
   assign chip_wr   = chip_wr_q;

endmodule

// File: tb/tb_jt12_rst_clr.sv
// tb/tb_jt12_rst_clr.sv - self-checking bench for the post-reset register clear sequencer
module tb_jt12_rst_clr;

   localparam int NTXN = 552;
   localparam int LIMIT = 8000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst0 = 1'b1;
   logic       cen = 1'b0;
   logic [1:0] cpu_addr = 2'd0;
   logic [7:0] cpu_din = 8'd0;
   logic       cpu_wr = 1'b0;

   logic       busy, cpu_lost, chip_wr;
   logic [1:0] chip_addr;
   logic [7:0] chip_din;
   logic       busy0, cpu_lost0, chip_wr0;
   logic [1:0] chip_addr0;
   logic [7:0] chip_din0;

   logic       use0 = 1'b0;
   wire        m_busy = use0 ? busy0 : busy;
   wire        m_lost = use0 ? cpu_lost0 : cpu_lost;
   wire        m_wr   = use0 ? chip_wr0 : chip_wr;
   wire [1:0]  m_addr = use0 ? chip_addr0 : chip_addr;
   wire [7:0]  m_din  = use0 ? chip_din0 : chip_din;

   jt12_rst_clr #(.WAIT(2)) dut (
      .clk(clk), .rst(rst), .cen(cen),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr),
      .busy(busy), .cpu_lost(cpu_lost),
      .chip_addr(chip_addr), .chip_din(chip_din), .chip_wr(chip_wr)
   );

   jt12_rst_clr #(.WAIT(0)) dut0 (
      .clk(clk), .rst(rst0), .cen(1'b1),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr),
      .busy(busy0), .cpu_lost(cpu_lost0),
      .chip_addr(chip_addr0), .chip_din(chip_din0), .chip_wr(chip_wr0)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_addr[$];
   logic [7:0] exp_din[$];
   logic [1:0] cap_addr[$];
   logic [7:0] cap_din[$];
   int         cap_tick[$];
   int         fall_edge, fall_tick, nocen;
   logic       lost_pre;

   typedef struct {
      logic       wr;
      logic [1:0] addr;
      logic [7:0] din;
      logic       exp_wr;
      logic [1:0] exp_addr;
      logic [7:0] exp_din;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   // Reference write list: key-off writes, then every operator reg of bank 0 and bank 1
   task automatic build_model();
      int kv[6] = '{0, 1, 2, 4, 5, 6};
      for (int i = 0; i < 6; i++) begin
         exp_addr.push_back(2'd0); exp_din.push_back(8'h28);
         exp_addr.push_back(2'd1); exp_din.push_back(8'(kv[i]));
      end
      for (int b = 0; b < 2; b++) begin
         for (int r = 'h30; r <= 'hB6; r++) begin
            exp_addr.push_back({1'(b), 1'b0}); exp_din.push_back(8'(r));
            exp_addr.push_back({1'(b), 1'b1});
            exp_din.push_back((r >= 'h40 && r <= 'h4F) ? 8'h7F : 8'h00);
         end
      end
   endtask

   task automatic do_reset(input bit zero);
      cpu_wr = 1'b0;
      cen    = 1'b1;
      if (zero) rst0 = 1'b1; else rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset state", {m_busy, m_lost, m_wr, m_addr, m_din}, 13'h1000);
      if (zero) rst0 = 1'b0; else rst = 1'b0;
   endtask

   // mode 0: cen every clk, 1: every 4th clk, 2: random; capture strobes until busy falls
   task automatic run_seq(input int mode, input int lost_edge, input int stop_after);
      int   tick = 0;
      int   this_tick;
      logic c;
      cap_addr.delete(); cap_din.delete(); cap_tick.delete();
      fall_edge = -1; fall_tick = -1; nocen = 0; lost_pre = 1'bx;
      for (int cyc = 0; cyc < LIMIT; cyc++) begin
         case (mode)
            0:       c = 1'b1;
            1:       c = (cyc % 4 == 0);
            default: c = ($urandom_range(0, 2) == 0);
         endcase
         if (cyc == lost_edge - 1) lost_pre = m_lost;
         cpu_wr   = (cyc == lost_edge);
         cpu_addr = 2'd1;
         cpu_din  = 8'hAA;
         cen      = c;
         @(posedge clk);
         #1;
         this_tick = tick;
         if (c) tick++;
         if (m_wr) begin
            cap_addr.push_back(m_addr);
            cap_din.push_back(m_din);
            cap_tick.push_back(this_tick);
            if (!c) nocen++;
         end
         if (!m_busy) begin
            fall_edge = cyc;
            fall_tick = this_tick;
            break;
         end
         if (stop_after > 0 && cap_addr.size() == stop_after) break;
      end
      cpu_wr = 1'b0;
   endtask

   task automatic check_run(input string nm, input int wait_n, input int exp_edge);
      int mis  = -1;
      int badt = 0;
      chk({nm, " strobe count"}, cap_addr.size(), NTXN);
      for (int k = 0; k < cap_addr.size() && k < NTXN; k++) begin
         if (mis < 0 && (cap_addr[k] !== exp_addr[k] || cap_din[k] !== exp_din[k])) mis = k;
         if (cap_tick[k] != k * (1 + wait_n)) badt++;
      end
      chk({nm, " first wrong write index"}, mis, -1);
      chk({nm, " strobes off their tick"}, badt, 0);
      chk({nm, " strobes without cen"}, nocen, 0);
      chk({nm, " busy fall tick"}, fall_tick, NTXN * (1 + wait_n));
      if (exp_edge >= 0) chk({nm, " busy fall clk"}, fall_edge, exp_edge);
   endtask

   initial begin
      logic       pw;
      logic [1:0] pa;
      logic [7:0] pd;

      vecs[0] = '{1'b1, 2'd2, 8'h55, 1'b1, 2'd2, 8'h55};
      vecs[1] = '{1'b0, 2'd3, 8'h12, 1'b0, 2'd3, 8'h12};
      vecs[2] = '{1'b1, 2'd0, 8'h28, 1'b1, 2'd0, 8'h28};
      vecs[3] = '{1'b1, 2'd1, 8'hFF, 1'b1, 2'd1, 8'hFF};
      vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00};
      vecs[5] = '{1'b1, 2'd3, 8'hA5, 1'b1, 2'd3, 8'hA5};
      build_model();

      // cen every clk, a CPU write lands mid-sequence
      use0 = 1'b0;
      do_reset(1'b0);
      run_seq(0, 500, 0);
      check_run("cen1", 2, 1656);
      chk("lost after busy write", m_lost, 1);

      for (int i = 0; i < 6; i++) begin
         cpu_wr = vecs[i].wr; cpu_addr = vecs[i].addr; cpu_din = vecs[i].din;
         @(posedge clk);
         #1;
         chk($sformatf("pass vec %0d", i), {m_busy, m_wr, m_addr, m_din},
             {1'b0, vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].exp_din});
      end
      for (int i = 0; i < 200; i++) begin
         pw = 1'($urandom); pa = 2'($urandom); pd = 8'($urandom);
         cpu_wr = pw; cpu_addr = pa; cpu_din = pd;
         cen = 1'($urandom);
         @(posedge clk);
         #1;
         chk("random pass", {m_busy, m_wr, m_addr, m_din}, {1'b0, pw, pa, pd});
         cpu_wr = ~pw; cpu_addr = ~pa; cpu_din = ~pd;
         #1;
         chk("pass one clk latency", {m_wr, m_addr, m_din}, {pw, pa, pd});
      end
      cpu_wr = 1'b0;
      chk("lost stays sticky", m_lost, 1);

      // cen every 4th clk, CPU write on the very edge busy falls
      do_reset(1'b0);
      run_seq(1, 6624, 0);
      check_run("cen4", 2, 6624);
      chk("lost clear before fall edge", lost_pre, 0);
      chk("lost set on fall edge", m_lost, 1);
      chk("write on fall edge dropped", m_wr, 0);

      // random cen pacing
      do_reset(1'b0);
      run_seq(2, -1, 0);
      check_run("rand cen", 2, -1);
      chk("lost untouched", m_lost, 0);

      // reset mid-sequence at transaction 300, then full restart
      do_reset(1'b0);
      run_seq(0, 100, 300);
      chk("stop at transaction 300", cap_addr.size(), 300);
      chk("lost before mid reset", m_lost, 1);
      #2 rst = 1'b1;
      #1;
      chk("async reset state", {m_busy, m_lost, m_wr, m_addr, m_din}, 13'h1000);
      do_reset(1'b0);
      run_seq(0, -1, 0);
      check_run("restart", 2, 1656);

      // WAIT=0 instance: one strobe per clk
      use0 = 1'b1;
      do_reset(1'b1);
      run_seq(0, -1, 0);
      check_run("wait0", 0, 552);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
